// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligns stores, extends loads, drives a req/gnt/rvalid data bus.
// Optional watchdog abort enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_wstrb_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]            r_state;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_wstrb;
  logic [31:0]           r_wdata;
  logic [2:0]            r_funct3;
  logic [31:0]           r_rdata;
  logic                  r_bus_err;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_misalign;
  logic [3:0]            w_strb;
  logic [31:0]           w_lane_data;
  logic [31:0]           w_shifted;
  logic [31:0]           w_ld_ext;
  logic                  w_timeout;

  assign w_accept = req_valid_i && (r_state == S_IDLE);

  // Request decode: legality, alignment and store lane placement.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_legal     = 1'b0;
    w_strb      = 4'hF;
    w_lane_data = wdata_i;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !is_store_i;
      default:                w_legal = 1'b0;
    endcase
    w_misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    case (funct3_i[1:0])
      2'b00: begin
        w_strb      = 4'b0001 << addr_i[1:0];
        w_lane_data = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_strb      = 4'b0011 << addr_i[1:0];
        w_lane_data = {2{wdata_i[15:0]}};
      end
      default: begin
        w_strb      = 4'hF;
        w_lane_data = wdata_i;
      end
    endcase
  end

  // Load extraction uses the registered offset and width, not the live core inputs.
  assign w_shifted = mem_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ld_ext = mem_rdata_i;
    case (r_funct3)
      3'b000:  w_ld_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ld_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ld_ext = {24'h0, w_shifted[7:0]};
      3'b101:  w_ld_ext = {16'h0, w_shifted[15:0]};
      default: w_ld_ext = mem_rdata_i;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  // Fires on the TIMEOUT_CYCLES-th REQ/WAIT cycle when the bus has not completed.
  assign w_timeout = ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wstrb   <= 4'h0;
      r_wdata   <= 32'h0;
      r_funct3  <= 3'b000;
      r_rdata   <= 32'h0;
      r_bus_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we      <= is_store_i;
            r_addr    <= addr_i;
            r_wstrb   <= is_store_i ? w_strb : 4'h0;
            r_wdata   <= w_lane_data;
            r_funct3  <= funct3_i;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b0;
            r_state   <= (!w_legal || w_misalign) ? S_FAULT : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            if (r_we) begin
              r_state <= S_DONE;
            end else if (mem_rvalid_i) begin
              r_rdata <= w_ld_ext;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            r_rdata <= w_ld_ext;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus fields are only driven while a request is on the bus.
  assign req_ready_o = (r_state == S_IDLE);
  assign mem_req_o   = (r_state == S_REQ);
  assign mem_we_o    = mem_req_o && r_we;
  assign mem_addr_o  = mem_req_o ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem_wstrb_o = mem_req_o ? r_wstrb : 4'h0;
  assign mem_wdata_o = mem_req_o ? r_wdata : 32'h0;
  assign rsp_valid_o = (r_state == S_DONE) || (r_state == S_FAULT);
  assign rsp_rdata_o = (r_state == S_DONE) ? r_rdata : 32'h0;
  assign misalign_o  = (r_state == S_FAULT);
  assign bus_err_o   = (r_state == S_DONE) && r_bus_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random transactions
// checked against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        misalign_o;
  logic        bus_err_o;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size from funct3, plain arithmetic on byte offsets.
  function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = a % 4;
    if (st && f3 > 3'd2) return 1'b1;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) return 1'b1;
    if (f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = a % 4;
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    int unsigned sh = 8 * (a % 4);
    logic [31:0] b = (w >> sh) & 32'hFF;
    logic [31:0] h = (w >> sh) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // One transaction: gd = cycles gnt is withheld, rdl = cycles from gnt to rvalid.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int gd, input int rdl);
    bit          flt;
    int          g_c, r_c, rsp_c;
    logic [31:0] er;
    flt   = m_fault(st, f3, a);
    g_c   = 1 + gd;
    r_c   = 1 + gd + rdl;
    rsp_c = flt ? 1 : (st ? 2 + gd : 2 + gd + rdl);
    er    = (flt || st) ? 32'h0 : m_load(f3, a, rd);
    @(posedge clk_i); #1;
    req_valid_i  = 1'b1;
    is_store_i   = st;
    funct3_i     = f3;
    addr_i       = a;
    wdata_i      = wd;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("ready_at_accept", 32'(req_ready_o), 32'd1);
    for (int c = 1; c <= rsp_c + 1; c++) begin
      @(posedge clk_i); #1;
      req_valid_i  = (c < rsp_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      is_store_i   = 1'($urandom_range(0, 1));
      addr_i       = $urandom;
      wdata_i      = $urandom;
      mem_gnt_i    = !flt && (c == g_c);
      mem_rvalid_i = !flt && !st && (c == r_c);
      mem_rdata_i  = (c == r_c) ? rd : $urandom;
      @(negedge clk_i);
      if (c < rsp_c) begin
        check("busy_no_rsp", 32'(rsp_valid_o), 32'd0);
        check("busy_not_ready", 32'(req_ready_o), 32'd0);
        if (c <= g_c) begin
          check("req_held", 32'(mem_req_o), 32'd1);
          check("req_addr", mem_addr_o, a & 32'hFFFF_FFFC);
          check("req_we", 32'(mem_we_o), 32'(st));
          check("req_strb", 32'(mem_wstrb_o), st ? 32'(m_strb(f3, a)) : 32'd0);
          if (st) check("req_wdata", mem_wdata_o, m_wdata(f3, wd));
        end else begin
          check("wait_req_low", 32'(mem_req_o), 32'd0);
        end
      end else if (c == rsp_c) begin
        check("rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("rsp_rdata", rsp_rdata_o, er);
        check("rsp_misalign", 32'(misalign_o), 32'(flt));
        check("rsp_bus_err", 32'(bus_err_o), 32'd0);
        check("rsp_req_low", 32'(mem_req_o), 32'd0);
      end else begin
        check("after_no_rsp", 32'(rsp_valid_o), 32'd0);
        check("after_ready", 32'(req_ready_o), 32'd1);
      end
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    is_store_i   = 1'b0;
    funct3_i     = 3'b000;
    addr_i       = 32'h0;
    wdata_i      = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h1234_5678;

    // Reset state, with stray rvalid present.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_wstrb", 32'(mem_wstrb_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    #1 rst_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      check("idle_rvalid_ignored", 32'(rsp_valid_o), 32'd0);
    end
    mem_rvalid_i = 1'b0;

    // Directed cases.
    run_txn(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    run_txn(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 2, 0);
    run_txn(1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1, 0);
    run_txn(1'b0, 3'b000, 32'h0000_0201, 32'h0, 32'h0000_8000, 0, 1);
    run_txn(1'b0, 3'b100, 32'h0000_0201, 32'h0, 32'h0000_8000, 0, 1);
    run_txn(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_0000, 0, 0);
    run_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h8001_0000, 3, 2);
    run_txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 0);
    run_txn(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    run_txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    run_txn(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'hCAFE_F00D, 1, 1);

    // Reset while waiting for rvalid: no response, late rvalid ignored.
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_req", 32'(mem_req_o), 32'd1);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0; rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_wait_req_low", 32'(mem_req_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk_i);
    check("mid_rst_idle_ready", 32'(req_ready_o), 32'd1);
    check("mid_rst_no_rsp", 32'(rsp_valid_o), 32'd0);
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_late_rvalid", 32'(rsp_valid_o), 32'd0);

`ifdef LSU_TIMEOUT_EN
    // Withheld grant aborts after 16 REQ cycles.
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h100;
    wdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk_i);
      if (c < 17) begin
        check("to_req_held", 32'(mem_req_o), 32'd1);
        check("to_no_rsp", 32'(rsp_valid_o), 32'd0);
      end else begin
        check("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
        check("to_bus_err", 32'(bus_err_o), 32'd1);
        check("to_rdata_zero", rsp_rdata_o, 32'h0);
        check("to_req_dropped", 32'(mem_req_o), 32'd0);
      end
      @(posedge clk_i); #1;
    end
`endif

    // Random transactions against the reference model.
    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
